// File: rtl/ps2_host_tx.sv
// ps2_host_tx - host-to-device PS/2 transmitter.
//
// Software writes a command byte to TXDATA. The block then:
//   1. holds the PS/2 clock low (inhibit),
//   2. pulls data low to present the start bit,
//   3. releases the clock and shifts out 8 data bits (LSB first), odd parity
//      and the stop bit on the falling edges that the device generates,
//   4. samples the device ACK, then waits for the bus to go idle.
// A watchdog ends the transfer with an error if the device stops clocking.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   a            register select: 0 = TXDATA, 1 = STATUS
//   d            write data
//   we           write strobe, one cycle per write
//   spo          read data, combinational from a
//                  TXDATA: {24'b0, last byte}
//                  STATUS: {28'b0, dropped, err, ack_ok, busy}
//   irq          one-cycle pulse when a transfer ends (ACK or error)
//   rx_inhibit   high while busy, so the PS/2 receiver ignores our own frame
//   ps2_clk_i    PS/2 clock pad input (asynchronous)
//   ps2_data_i   PS/2 data pad input (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe  1 = pull PS/2 data low, 0 = release
module ps2_host_tx #(
  parameter int CLOCK_FREQ = 62500000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000,
  parameter int FILTER     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq,
  output logic        rx_inhibit,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe
);

  localparam int INH_CYC   = (CLOCK_FREQ / 1000) * INHIBIT_US / 1000;
  localparam int TO_CYC    = (CLOCK_FREQ / 1000) * TIMEOUT_US / 1000;
  localparam int START_CYC = 16;

  // One counter serves the inhibit/start timers and the watchdog, since they
  // are never active in the same state.
  localparam int MAX_AB  = (INH_CYC > START_CYC) ? INH_CYC : START_CYC;
  localparam int MAX_CYC = (TO_CYC > MAX_AB) ? TO_CYC : MAX_AB;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int FW      = $clog2(FILTER + 1);

  localparam logic [CW-1:0] INH_LAST   = CW'(INH_CYC - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_CYC - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TO_CYC - 1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    n_q, n_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          parity_q, parity_d;
  logic          ack_ok_q, ack_ok_d;
  logic          err_q, err_d;
  logic          dropped_q, dropped_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          irq_q, irq_d;
  logic          rx_inh_q, rx_inh_d;

  // Index 0 = PS/2 clock, index 1 = PS/2 data.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    filt_q;
  logic [FW-1:0] fcnt_q [2];
  logic          clk_prev_q;

  logic fall;
  logic wd_expired;
  logic wr_tx, wr_status;
  logic busy;

  // Only d[7:0] (TXDATA) and d[0] (STATUS clear) carry meaning.
  logic unused_d;
  assign unused_d = ^d[31:8];

  // Input conditioning: two-flop synchroniser, then a level is accepted only
  // after it has differed from the current filtered level for FILTER
  // consecutive cycles, which removes short glitches on the cable.
  // NOTE: every register here uses <=, so all flops see the values from
  // before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      sync1_q    <= {ps2_data_i, ps2_clk_i};
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FILT_LAST) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fall       = clk_prev_q & ~filt_q[0];
  assign wd_expired = (cnt_q == TO_LAST);
  assign wr_tx      = we & ~a;
  assign wr_status  = we & a;
  assign busy       = (state_q != IDLE);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    ack_ok_d  = ack_ok_q;
    err_d     = err_q;
    dropped_d = dropped_q;
    data_oe_d = data_oe_q;
    irq_d     = 1'b0;

    if (wr_status && d[0]) begin
      ack_ok_d  = 1'b0;
      err_d     = 1'b0;
      dropped_d = 1'b0;
    end
    if (wr_tx && state_q != IDLE) begin
      dropped_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (wr_tx) begin
          shreg_d  = d[7:0];
          parity_d = ~^d[7:0];
          ack_ok_d = 1'b0;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      START: begin
        if (cnt_q == START_LAST) begin
          cnt_d   = '0;
          n_d     = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT, ACK, WAIT_IDLE: begin
        cnt_d = cnt_q + 1'b1;
        // The watchdog is checked first so it wins over a simultaneous fall.
        if (wd_expired) begin
          err_d   = 1'b1;
          irq_d   = 1'b1;
          state_d = IDLE;
        end else if (state_q == SHIFT) begin
          if (fall) begin
            n_d = n_q + 1'b1;
            if (n_q < 4'd8) begin
              data_oe_d = ~shreg_q[n_q[2:0]];
            end else if (n_q == 4'd8) begin
              data_oe_d = ~parity_q;
            end else begin
              data_oe_d = 1'b0;  // stop bit: release the line
              state_d   = ACK;
            end
          end
        end else if (state_q == ACK) begin
          if (fall) begin
            if (!filt_q[1]) ack_ok_d = 1'b1;
            else            err_d    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else if (filt_q == 2'b11) begin
          irq_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line drivers are decoded from the next state so they change on the
    // same edge as the state register and never glitch on the pads.
    clk_oe_d = (state_d == INHIBIT) || (state_d == START);
    unique case (state_d)
      INHIBIT: data_oe_d = (cnt_d == INH_LAST);
      START:   data_oe_d = 1'b1;
      SHIFT:   data_oe_d = data_oe_d;
      default: data_oe_d = 1'b0;
    endcase
    rx_inh_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      shreg_q   <= '0;
      parity_q  <= 1'b0;
      ack_ok_q  <= 1'b0;
      err_q     <= 1'b0;
      dropped_q <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      irq_q     <= 1'b0;
      rx_inh_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      shreg_q   <= shreg_d;
      parity_q  <= parity_d;
      ack_ok_q  <= ack_ok_d;
      err_q     <= err_d;
      dropped_q <= dropped_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      irq_q     <= irq_d;
      rx_inh_q  <= rx_inh_d;
    end
  end

  assign spo         = a ? {28'b0, dropped_q, err_q, ack_ok_q, busy}
                         : {24'b0, shreg_q};
  assign irq         = irq_q;
  assign rx_inhibit  = rx_inh_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx - directed bench for ps2_host_tx with a PS/2 device model
// (40-cycle clock period, samples data on rising edges, ACKs after bit 10).
module tb_ps2_host_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;
  logic        irq;
  logic        rx_inhibit;
  logic        ps2_clk_oe;
  logic        ps2_data_oe;
  logic        dev_clk;
  logic        dev_data;
  logic        ps2_clk_pad;
  logic        ps2_data_pad;

  int n_cmp = 0;
  int n_err = 0;
  int irq_total = 0;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_pad  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_pad = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  always @(negedge clk) if (irq === 1'b1) irq_total++;

  ps2_host_tx #(
    .CLOCK_FREQ(1000000),
    .INHIBIT_US(4),
    .TIMEOUT_US(2000),
    .FILTER    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .d          (d),
    .we         (we),
    .spo        (spo),
    .irq        (irq),
    .rx_inhibit (rx_inhibit),
    .ps2_clk_i  (ps2_clk_pad),
    .ps2_data_i (ps2_data_pad),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic sel, input logic [31:0] val);
    @(negedge clk);
    a  = sel;
    d  = val;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    a  = 1'b0;
  endtask

  task automatic read_reg(input logic sel, output logic [31:0] v);
    a = sel;
    #1;
    v = spo;
  endtask

  // Device side of one frame. bits[0] = start, [8:1] data, [9] parity, [10] stop.
  // abort_k > 0 returns after that many falls, leaving the clock low.
  task automatic dev_xfer(input logic ack, input int abort_k, input bit glitch,
                          input bit midwrite, output logic [10:0] bits,
                          output int clk_cyc, output int both_cyc);
    int t;
    bits     = '0;
    clk_cyc  = 0;
    both_cyc = 0;
    t = 0;
    while (!ps2_clk_oe && t < 100) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (ps2_clk_oe && t < 100) begin
      clk_cyc++;
      if (ps2_data_oe) both_cyc++;
      @(negedge clk);
      t++;
    end
    bits[0] = ps2_data_pad;
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      if (k == abort_k) return;
      bits[k] = ps2_data_pad;
      dev_clk = 1'b1;
      for (int i = 0; i < 20; i++) begin
        if (glitch && k == 3 && i == 8)  dev_clk = 1'b0;
        if (glitch && k == 3 && i == 10) dev_clk = 1'b1;
        if (midwrite && k == 3 && i == 8) begin
          a = 1'b0; d = 32'h0000_00AA; we = 1'b1;
        end
        if (midwrite && k == 3 && i == 9) we = 1'b0;
        if (i == 5 && k == 10 && ack) dev_data = 1'b0;
        @(negedge clk);
      end
    end
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (rx_inhibit && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(tag, {31'b0, rx_inhibit}, 32'h0);
    repeat (3) @(negedge clk);
  endtask

  logic [10:0] bits;
  logic [31:0] v;
  int          cc, bc, irq0, t;

  initial begin
    rst = 1'b1; a = 1'b0; d = '0; we = 1'b0;
    dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'h0);
    check("rst_irq_inh", {30'b0, irq, rx_inhibit}, 32'h0);
    read_reg(1'b1, v); check("rst_status", v, 32'h0);
    read_reg(1'b0, v); check("rst_txdata", v, 32'h0);

    // 1: 0xED with ACK
    irq0 = irq_total;
    bus_write(1'b0, 32'h0000_00ED);
    dev_xfer(1'b1, 0, 1'b0, 1'b0, bits, cc, bc);
    check("t1_clk_oe_cycles", cc, 32'd20);
    check("t1_data_oe_cycles", bc, 32'd17);
    check("t1_bits", {21'b0, bits}, {21'b0, 2'b11, 8'hED, 1'b0});
    wait_idle("t1_idle");
    read_reg(1'b1, v); check("t1_status", v, 32'h2);
    check("t1_irq", irq_total - irq0, 32'd1);
    check("t1_rx_inhibit", {31'b0, rx_inhibit}, 32'h0);
    read_reg(1'b0, v); check("t1_txdata", v, 32'h0000_00ED);

    // 2: 0x00 without ACK
    irq0 = irq_total;
    bus_write(1'b0, 32'h0000_0000);
    dev_xfer(1'b0, 0, 1'b0, 1'b0, bits, cc, bc);
    check("t2_bits", {21'b0, bits}, {21'b0, 2'b11, 8'h00, 1'b0});
    wait_idle("t2_idle");
    read_reg(1'b1, v); check("t2_status", v, 32'h4);
    check("t2_irq", irq_total - irq0, 32'd1);

    // 3: 0xFF, device never clocks -> watchdog after 2000 cycles in SHIFT
    irq0 = irq_total;
    bus_write(1'b0, 32'h0000_00FF);
    t = 0;
    while (!ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    cc = 0;
    while (rx_inhibit && cc < 3000) begin cc++; @(negedge clk); end
    check("t3_busy_cycles", cc, 32'd2000);
    check("t3_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'h0);
    repeat (3) @(negedge clk);
    read_reg(1'b1, v); check("t3_status", v, 32'h4);
    check("t3_irq", irq_total - irq0, 32'd1);

    // 4: 0x55 with a write of 0xAA during SHIFT
    bus_write(1'b0, 32'h0000_0055);
    dev_xfer(1'b1, 0, 1'b0, 1'b1, bits, cc, bc);
    check("t4_bits", {21'b0, bits}, {21'b0, 2'b11, 8'h55, 1'b0});
    wait_idle("t4_idle");
    read_reg(1'b1, v); check("t4_status", v, 32'hA);
    read_reg(1'b0, v); check("t4_txdata", v, 32'h0000_0055);
    bus_write(1'b1, 32'h0000_0001);
    read_reg(1'b1, v); check("t4_status_clr", v, 32'h0);

    // 5: reset in SHIFT after four falls, then 0xF4
    bus_write(1'b0, 32'h0000_0066);
    dev_xfer(1'b1, 4, 1'b0, 1'b0, bits, cc, bc);
    read_reg(1'b1, v); check("t5_busy", v, 32'h1);
    irq0 = irq_total;
    dev_clk = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'h0);
    read_reg(1'b1, v); check("t5_status", v, 32'h0);
    repeat (50) @(negedge clk);
    check("t5_no_irq", irq_total - irq0, 32'd0);
    irq0 = irq_total;
    bus_write(1'b0, 32'h0000_00F4);
    dev_xfer(1'b1, 0, 1'b0, 1'b0, bits, cc, bc);
    check("t5_bits", {21'b0, bits}, {21'b0, 2'b10, 8'hF4, 1'b0});
    wait_idle("t5_idle");
    read_reg(1'b1, v); check("t5_status_f4", v, 32'h2);
    check("t5_irq", irq_total - irq0, 32'd1);

    // 6: 2-cycle glitch on the clock during SHIFT
    bus_write(1'b0, 32'h0000_00A7);
    dev_xfer(1'b1, 0, 1'b1, 1'b0, bits, cc, bc);
    check("t6_bits", {21'b0, bits}, {21'b0, 2'b10, 8'hA7, 1'b0});
    wait_idle("t6_idle");
    read_reg(1'b1, v); check("t6_status", v, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
